mult_div_unit: RTL
==================

# mult_div_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file read ports. It consumes the two read operands on a `start` pulse and computes the product or quotient/remainder over 33 cycles, holding the results in architectural HI/LO registers. Control stalls the pipeline on `busy`. The mfhi/mflo path reads `hi`/`lo` back into register-file write data.

## Interface
Parameters:
- `WordLen`, 32, operand and HI/LO width; must be a power of two and at least 8.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin an operation; sampled only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  WordLen  operand 1, from register file `readData1`.
- `b`  in  WordLen  operand 2, from register file `readData2`.
- `hi_we`  in  1  mthi write strobe.
- `lo_we`  in  1  mtlo write strobe.
- `wdata`  in  WordLen  mthi/mtlo data.
- `busy`  out  1  operation in progress; the pipeline stalls on it.
- `done`  out  1  one-cycle pulse when HI/LO receive a new result.
- `hi`  out  WordLen  HI register: product upper half, or remainder.
- `lo`  out  WordLen  LO register: product lower half, or quotient.

## Operation
- States:
  - IDLE: accepts `start` and mthi/mtlo writes.
  - CALC: runs 32 iterations, tracked by a counter.
  - FIX: applies sign correction and writes HI/LO.
- IDLE→CALC on `start`.
  - Latches `op`, the absolute values of `a` and `b` (raw values for unsigned ops), and the result signs.
  - Clears the counter.
- CALC:
  - Multiply: one shift-add step per cycle on a 2·WordLen accumulator.
  - Divide: one restoring shift-subtract step per cycle, using a WordLen+1-bit adder.
  - Leaves to FIX after counter = WordLen−1.
- FIX→IDLE:
  - Negates the product if the signs differ (MULT).
  - Negates the quotient if the signs differ (DIV).
  - Gives the remainder the sign of the dividend (DIV).
  - Writes HI/LO.
- Width rules:
  - MULT/MULTU: {hi,lo} = full 2·WordLen product.
  - DIV: quotient truncates toward zero.
- Divide by zero (DIV or DIVU): lo = all ones, hi = `a` unchanged. No exception is raised.
- Signed overflow (−2^(W−1) / −1): lo = 0x80000000, hi = 0 (two's-complement wrap).
- `start` while not IDLE is ignored; control must hold it off using `busy`.
- `hi_we`/`lo_we` are applied only in IDLE; they are ignored while `busy`.
  - If applied in the same cycle as `start`, the write lands and the later result overwrites it.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, counter 0.
- Call the accepting edge E0. Then:
  - `busy` is high from after E0 through E33, i.e. 33 cycles, combinational from state ≠ IDLE.
  - The HI/LO update happens at E33.
  - `done` is high for exactly the cycle after E33.
  - `busy` is low in that same cycle.
- Back-to-back: `start` in the cycle where `done`=1 is accepted, so the minimum issue interval is 34 cycles.
- `rst` mid-operation aborts immediately: all outputs return to their reset values and no partial result is written.
- `hi`/`lo` are stable and readable throughout CALC; they hold the previous result until E33.

## Structure
- Shared package holds:
  - Op encodings: `OP_MULTU`, `OP_MULT`, `OP_DIVU`, `OP_DIV`.
  - State encodings: IDLE, CALC, FIX.
  - The default `WordLen`.
- The FSM and counter live in this module.
- One sub-module is natural: `mdu_datapath`, holding the accumulator, the shared adder, and the sign-fix negators.

## Test plan
- MULTU a=0xFFFFFFFF, b=2 → at E33 hi=0x00000001, lo=0xFFFFFFFE; `done` pulses once; `busy` high for exactly 33 cycles.
- MULT a=−3, b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=100. DIV a=0x80000000, b=−1 → lo=0x80000000, hi=0.
- `start` re-asserted during CALC with different operands → ignored; the first result is unchanged and the timing is still 33 cycles. `start` in the `done` cycle → accepted.
- mtlo wdata=0x1234 in IDLE → lo=0x1234 next cycle. `hi_we` during CALC → hi unchanged.
- `rst` at cycle 10 of a DIVU → `busy`=0, hi=lo=0 immediately. A fresh MULTU 6×7 afterwards → lo=42, hi=0.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state encodings, default word length and
// small op-decoding helpers used by the top and the datapath.
package mult_div_unit_pkg;

  localparam int WORD_LEN_DEFAULT = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // op[1] selects divide, op[0] selects signed operands
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Multiply/divide datapath: 2W accumulator, one shared (W+1)-bit adder
// used for shift-add multiply and restoring divide, and sign-fix negators.
// Results are presented combinationally; the top captures them in FIX.
module mdu_datapath
  import mult_div_unit_pkg::*;
#(
  parameter int WordLen = WORD_LEN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [1:0]         op,
  input  logic [WordLen-1:0] a,
  input  logic [WordLen-1:0] b,
  output logic [WordLen-1:0] res_hi,
  output logic [WordLen-1:0] res_lo
);

  localparam int W = WordLen;

  logic [2*W-1:0] acc;
  logic [W-1:0]   opnd_b;
  logic           is_div;
  logic           neg_q;
  logic           neg_r;
  logic           div0;

  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic [W:0]     add_x;
  logic [W:0]     add_y;
  logic           add_cin;
  logic [W:0]     sum;
  logic [2*W-1:0] acc_step;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;

  // Magnitudes of the operands; unsigned ops pass the raw values through
  always_comb begin
    abs_a = (op_is_signed(op) && a[W-1]) ? -a : a;
    abs_b = (op_is_signed(op) && b[W-1]) ? -b : b;
  end

  // Shared adder: multiply adds the multiplicand into the upper half when the
  // current multiplier bit is set; divide subtracts the divisor from the
  // shifted partial remainder and restores on borrow (sign bit of the sum).
  always_comb begin
    add_x    = '0;
    add_y    = '0;
    add_cin  = 1'b0;
    acc_step = acc;
    if (is_div) begin
      add_x   = {acc[2*W-1:W], acc[W-1]};
      add_y   = ~{1'b0, opnd_b};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc[2*W-1:W]};
      add_y   = acc[0] ? {1'b0, opnd_b} : '0;
    end
    sum = add_x + add_y + {{W{1'b0}}, add_cin};
    if (is_div) begin
      acc_step = sum[W] ? {add_x[W-1:0], acc[W-2:0], 1'b0}
                        : {sum[W-1:0],   acc[W-2:0], 1'b1};
    end else begin
      acc_step = {sum, acc[W-1:1]};
    end
  end

  // Operand capture on accept, one iteration per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      opnd_b <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else if (load) begin
      acc    <= {{W{1'b0}}, abs_a};
      opnd_b <= abs_b;
      is_div <= op_is_div(op);
      neg_q  <= op_is_signed(op) && (a[W-1] ^ b[W-1]);
      neg_r  <= op_is_signed(op) && a[W-1];
      div0   <= (b == '0);
    end else if (step) begin
      acc    <= acc_step;
    end
  end

  // Sign correction. A zero divisor leaves the quotient at all ones and the
  // remainder at |a|, which re-signed with the dividend sign gives back a.
  always_comb begin
    prod   = neg_q ? -acc : acc;
    quo    = acc[W-1:0];
    rem    = acc[2*W-1:W];
    res_hi = prod[2*W-1:W];
    res_lo = prod[W-1:0];
    if (is_div) begin
      res_lo = (neg_q && !div0) ? -quo : quo;
      res_hi = neg_r ? -rem : rem;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Latency: 33 cycles from accept to HI/LO update, done pulses the cycle after.
// Backpressure: busy high while running; start and mthi/mtlo ignored then.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WordLen = WORD_LEN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WordLen-1:0] a,
  input  logic [WordLen-1:0] b,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [WordLen-1:0] wdata,
  output logic               busy,
  output logic               done,
  output logic [WordLen-1:0] hi,
  output logic [WordLen-1:0] lo
);

  localparam int CntW = $clog2(WordLen);

  state_e            state;
  state_e            state_nxt;
  logic [CntW-1:0]   cnt;
  logic              load;
  logic              step;
  logic [WordLen-1:0] res_hi;
  logic [WordLen-1:0] res_lo;

  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath controls
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == CntW'(WordLen - 1)) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration counter: cleared on accept, advanced each CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + CntW'(1);
  end

  // HI/LO: result capture in FIX, mthi/mtlo writes only while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (state == FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

  mdu_datapath #(.WordLen(WordLen)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

endmodule
